// File: rtl/conv_loop_sequencer.sv
// Layer sequencer for the ifm/weight buffer -> 4-lane MAC -> accumulator -> output buffer path.
// Walks m->r->c->i->j->n, issues one read per cycle and aligns accumulator and write strobes.
module conv_loop_sequencer #(
    parameter int unsigned M   = 4,
    parameter int unsigned R   = 4,
    parameter int unsigned C   = 4,
    parameter int unsigned K   = 3,
    parameter int unsigned NW  = 1,
    parameter int unsigned S   = 1,
    parameter int unsigned LAT = 2,
    parameter int unsigned AW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          mem_en,
    output logic [AW-1:0] ifm_addr,
    output logic [AW-1:0] weight_addr,
    output logic          acc_clear,
    output logic          acc_enable,
    output logic          out_we,
    output logic [AW-1:0] out_addr
);

    localparam int unsigned CW = 16;
    localparam int unsigned IW = (C - 1) * S + K;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [CW-1:0] n_q, n_d, j_q, j_d, i_q, i_d;
    logic [CW-1:0] c_q, c_d, r_q, r_d, m_q, m_d;

    logic wrap_n, wrap_j, wrap_i, wrap_c, wrap_r, wrap_m;
    logic carry_j, carry_i, carry_c, carry_r, carry_m;
    logic issue, is_first, is_last, final_issue;

    logic [AW-1:0] oaddr;
    logic [LAT-1:0] en_pipe, clr_pipe, we_pipe;
    logic [AW-1:0]  oaddr_pipe [LAT];
    logic           out_we_q;
    logic [AW-1:0]  out_addr_q;

    assign issue  = (state_q == StRun) && !hold;
    assign mem_en = issue;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

    assign wrap_n = (n_q == CW'(NW - 1));
    assign wrap_j = (j_q == CW'(K - 1));
    assign wrap_i = (i_q == CW'(K - 1));
    assign wrap_c = (c_q == CW'(C - 1));
    assign wrap_r = (r_q == CW'(R - 1));
    assign wrap_m = (m_q == CW'(M - 1));

    assign carry_j = wrap_n;
    assign carry_i = carry_j && wrap_j;
    assign carry_c = carry_i && wrap_i;
    assign carry_r = carry_c && wrap_c;
    assign carry_m = carry_r && wrap_r;

    assign is_first    = (n_q == '0) && (j_q == '0) && (i_q == '0);
    assign is_last     = carry_c;
    assign final_issue = issue && carry_m && wrap_m;

    // Addresses are pure functions of the counters so they line up with mem_en.
    assign ifm_addr = AW'(((32'(r_q) * S + 32'(i_q)) * IW + (32'(c_q) * S + 32'(j_q))) * NW
                          + 32'(n_q));
    assign weight_addr = AW'(((32'(m_q) * K + 32'(i_q)) * K + 32'(j_q)) * NW + 32'(n_q));
    assign oaddr = AW'((32'(m_q) * R + 32'(r_q)) * C + 32'(c_q));

    always_comb begin
        n_d = n_q;
        j_d = j_q;
        i_d = i_q;
        c_d = c_q;
        r_d = r_q;
        m_d = m_q;
        if (issue) begin
            n_d = wrap_n ? '0 : n_q + 1'b1;
            if (carry_j) j_d = wrap_j ? '0 : j_q + 1'b1;
            if (carry_i) i_d = wrap_i ? '0 : i_q + 1'b1;
            if (carry_c) c_d = wrap_c ? '0 : c_q + 1'b1;
            if (carry_r) r_d = wrap_r ? '0 : r_q + 1'b1;
            if (carry_m) m_d = wrap_m ? '0 : m_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (final_issue) state_d = StDrain;
            // With no issues left, an out_we with an empty pipe is the last neuron.
            StDrain: if (out_we_q && (we_pipe == '0)) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            j_q     <= '0;
            i_q     <= '0;
            c_q     <= '0;
            r_q     <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            j_q     <= j_d;
            i_q     <= i_d;
            c_q     <= c_d;
            r_q     <= r_d;
            m_q     <= m_d;
        end
    end

    // Delay lines keep shifting under hold; an idle slot shifts in as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_pipe    <= '0;
            clr_pipe   <= '0;
            we_pipe    <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            for (int k = 0; k < LAT; k++) oaddr_pipe[k] <= '0;
        end else begin
            en_pipe[0]    <= issue;
            clr_pipe[0]   <= issue && is_first;
            we_pipe[0]    <= issue && is_last;
            oaddr_pipe[0] <= oaddr;
            for (int k = 1; k < LAT; k++) begin
                en_pipe[k]    <= en_pipe[k-1];
                clr_pipe[k]   <= clr_pipe[k-1];
                we_pipe[k]    <= we_pipe[k-1];
                oaddr_pipe[k] <= oaddr_pipe[k-1];
            end
            out_we_q <= we_pipe[LAT-1];
            if (we_pipe[LAT-1]) out_addr_q <= oaddr_pipe[LAT-1];
        end
    end

    assign acc_enable = en_pipe[LAT-1];
    assign acc_clear  = clr_pipe[LAT-1];
    assign out_we     = out_we_q;
    assign out_addr   = out_addr_q;

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Scoreboard bench for conv_loop_sequencer: three configurations share clock, reset and hold.
// A loop-nest model queues expected reads; a negedge monitor checks reads, accumulator and writes.
module tb_conv_loop_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       hold;
    logic [2:0] start;

    logic [2:0]  busy_v, done_v, mem_en_v, acc_clear_v, acc_enable_v, out_we_v;
    logic [15:0] ifm_v [3];
    logic [15:0] wgt_v [3];
    logic [15:0] oaddr_v [3];

    conv_loop_sequencer #(.M(1), .R(1), .C(1), .K(1), .NW(1), .S(1), .LAT(2), .AW(16)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .hold(hold), .busy(busy_v[0]),
        .done(done_v[0]), .mem_en(mem_en_v[0]), .ifm_addr(ifm_v[0]), .weight_addr(wgt_v[0]),
        .acc_clear(acc_clear_v[0]), .acc_enable(acc_enable_v[0]), .out_we(out_we_v[0]),
        .out_addr(oaddr_v[0])
    );

    conv_loop_sequencer #(.M(1), .R(1), .C(2), .K(3), .NW(1), .S(1), .LAT(2), .AW(16)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .hold(hold), .busy(busy_v[1]),
        .done(done_v[1]), .mem_en(mem_en_v[1]), .ifm_addr(ifm_v[1]), .weight_addr(wgt_v[1]),
        .acc_clear(acc_clear_v[1]), .acc_enable(acc_enable_v[1]), .out_we(out_we_v[1]),
        .out_addr(oaddr_v[1])
    );

    conv_loop_sequencer #(.M(2), .R(1), .C(1), .K(3), .NW(2), .S(1), .LAT(2), .AW(16)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .hold(hold), .busy(busy_v[2]),
        .done(done_v[2]), .mem_en(mem_en_v[2]), .ifm_addr(ifm_v[2]), .weight_addr(wgt_v[2]),
        .acc_clear(acc_clear_v[2]), .acc_enable(acc_enable_v[2]), .out_we(out_we_v[2]),
        .out_addr(oaddr_v[2])
    );

    int sel = 1;
    logic        busy_m, done_m, mem_en_m, acc_clear_m, acc_enable_m, out_we_m;
    logic [15:0] ifm_m, wgt_m, oaddr_m;

    always_comb begin
        busy_m       = busy_v[sel];
        done_m       = done_v[sel];
        mem_en_m     = mem_en_v[sel];
        acc_clear_m  = acc_clear_v[sel];
        acc_enable_m = acc_enable_v[sel];
        out_we_m     = out_we_v[sel];
        ifm_m        = ifm_v[sel];
        wgt_m        = wgt_v[sel];
        oaddr_m      = oaddr_v[sel];
    end

    typedef struct {
        int ifm;
        int wgt;
        int clr;
        int last;
        int oaddr;
    } iss_t;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    iss_t iss_q[$];
    ev_t  acc_q[$];
    ev_t  we_q[$];

    int cyc = 0;
    int t0 = 0;
    int tests = 0;
    int fails = 0;
    int n_done, n_we, first_mem, first_we, done_rel, second_first;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc - t0);
        end
    endtask

    task automatic model_push(input int m_n, input int r_n, input int c_n, input int k,
                              input int nw, input int s);
        int iw;
        iss_t e;
        iw = (c_n - 1) * s + k;
        for (int m = 0; m < m_n; m++)
            for (int r = 0; r < r_n; r++)
                for (int c = 0; c < c_n; c++)
                    for (int i = 0; i < k; i++)
                        for (int j = 0; j < k; j++)
                            for (int n = 0; n < nw; n++) begin
                                e.ifm   = ((r * s + i) * iw + (c * s + j)) * nw + n;
                                e.wgt   = ((m * k + i) * k + j) * nw + n;
                                e.clr   = (i == 0 && j == 0 && n == 0) ? 1 : 0;
                                e.last  = (i == k - 1 && j == k - 1 && n == nw - 1) ? 1 : 0;
                                e.oaddr = (m * r_n + r) * c_n + c;
                                iss_q.push_back(e);
                            end
    endtask

    always @(negedge clk) begin
        int   rel;
        iss_t e;
        ev_t  a;
        rel = cyc - t0;
        if (!rst) begin
            if (mem_en_m) begin
                if (first_mem < 0) first_mem = rel;
                if (n_done == 1 && second_first < 0) second_first = rel;
                if (iss_q.size() == 0) begin
                    check_eq("spurious_mem_en", int'(mem_en_m), 0);
                end else begin
                    e = iss_q.pop_front();
                    check_eq("ifm_addr", int'(ifm_m), e.ifm);
                    check_eq("weight_addr", int'(wgt_m), e.wgt);
                    acc_q.push_back('{rel + 2, e.clr});
                    if (e.last != 0) we_q.push_back('{rel + 3, e.oaddr});
                end
            end
            if (acc_enable_m) begin
                if (acc_q.size() == 0) begin
                    check_eq("spurious_acc_enable", int'(acc_enable_m), 0);
                end else begin
                    a = acc_q.pop_front();
                    check_eq("acc_enable_cycle", rel, a.cyc);
                    check_eq("acc_clear", int'(acc_clear_m), a.val);
                end
            end else if (acc_clear_m) begin
                check_eq("acc_clear_without_enable", int'(acc_clear_m), 0);
            end
            if (out_we_m) begin
                n_we++;
                if (first_we < 0) first_we = rel;
                if (we_q.size() == 0) begin
                    check_eq("spurious_out_we", int'(out_we_m), 0);
                end else begin
                    a = we_q.pop_front();
                    check_eq("out_we_cycle", rel, a.cyc);
                    check_eq("out_addr", int'(oaddr_m), a.val);
                end
            end
            if (done_m) begin
                n_done++;
                done_rel = rel;
                check_eq("busy_at_done", int'(busy_m), 1);
                check_eq("pending_at_done", acc_q.size() + we_q.size(), 0);
            end
        end
    end

    task automatic clear_track();
        iss_q.delete();
        acc_q.delete();
        we_q.delete();
        n_done       = 0;
        n_we         = 0;
        first_mem    = -1;
        first_we     = -1;
        done_rel     = -1;
        second_first = -1;
    endtask

    task automatic run_layer(input int s, input int m, input int r, input int c, input int k,
                             input int nw, input int hold_at, input int pulse_at,
                             input int layers, input int exp_done, input int exp_first_we);
        int rel;
        sel = s;
        clear_track();
        for (int l = 0; l < layers; l++) model_push(m, r, c, k, nw, 1);
        @(posedge clk);
        #1;
        check_eq("busy_before_start", int'(busy_m), 0);
        start[s] = 1'b1;
        t0 = cyc;
        for (int w = 0; w < 300 && n_done < layers; w++) begin
            @(posedge clk);
            #1;
            rel = cyc - t0;
            start[s] = ((layers > 1) && (n_done == 0)) || (rel == pulse_at);
            hold = (hold_at > 0) && (rel >= hold_at) && (rel < hold_at + 3);
        end
        start[s] = 1'b0;
        hold = 1'b0;
        check_eq("layers_done", n_done, layers);
        check_eq("done_cycle", done_rel, exp_done);
        check_eq("first_mem_cycle", first_mem, 1);
        check_eq("first_we_cycle", first_we, exp_first_we);
        check_eq("we_count", n_we, layers * m * r * c);
        check_eq("issues_left", iss_q.size(), 0);
        @(posedge clk);
        #1;
        check_eq("busy_after_done", int'(busy_m), 0);
        check_eq("done_after_done", int'(done_m), 0);
    endtask

    initial begin
        rst   = 1'b1;
        hold  = 1'b0;
        start = '0;
        clear_track();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", int'(busy_v), 0);
        check_eq("rst_mem_en", int'(mem_en_v), 0);
        check_eq("rst_out_we", int'(out_we_v | done_v | acc_enable_v), 0);
        check_eq("rst_addr", int'(ifm_v[2] | wgt_v[2] | oaddr_v[2]), 0);
        rst = 1'b0;

        // Single-issue layer.
        run_layer(0, 1, 1, 1, 1, 1, 0, 0, 1, 5, 4);
        // 3x3 kernel over two output columns.
        run_layer(1, 1, 1, 2, 3, 1, 0, 0, 1, 22, 12);
        // Two output channels, two words per pixel.
        run_layer(2, 2, 1, 1, 3, 2, 0, 0, 1, 40, 21);
        // hold for three cycles where issue 5 would go.
        run_layer(1, 1, 1, 2, 3, 1, 5, 0, 1, 25, 15);
        // start pulse while busy is ignored.
        run_layer(1, 1, 1, 2, 3, 1, 0, 6, 1, 22, 12);
        // start held high: back-to-back layers.
        run_layer(1, 1, 1, 2, 3, 1, 0, 0, 2, 44, 12);
        check_eq("second_layer_first_mem", second_first, 23);

        // Asynchronous reset mid-run.
        sel = 1;
        clear_track();
        model_push(1, 1, 2, 3, 1, 1);
        @(posedge clk);
        #1;
        start[1] = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", int'(busy_m), 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_ctl", int'({busy_m, done_m, mem_en_m, acc_clear_m, acc_enable_m,
                                      out_we_m}), 0);
        check_eq("rst_mid_ifm", int'(ifm_m), 0);
        check_eq("rst_mid_wgt", int'(wgt_m), 0);
        clear_track();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_eq("post_rst_we", n_we, 0);
        check_eq("post_rst_done", n_done, 0);
        check_eq("post_rst_busy", int'(busy_m), 0);
        run_layer(1, 1, 1, 2, 3, 1, 0, 0, 1, 22, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_loop_sequencer.md
Name: conv_loop_sequencer

Overview:
- Sequences one convolution layer over the ifm/weight buffer → 4-lane MAC → accumulator → output buffer datapath.
- Walks the loop nest m→r→c→i→j→n and issues one 64-bit read per cycle to the ifm and weight buffers.
- Drives accumulator clear/enable in step with the datapath latency, and emits the output-buffer write strobe and address once per finished neuron.
- Also provides the layer-level start/busy/done handshake.

Parameters:
- M, 4, output channels.
- R, 4, output rows.
- C, 4, output columns.
- K, 3, kernel size (K×K); range 1..15.
- NW, 1, 64-bit words per input pixel (input channels / 4); range 1..255.
- S, 1, convolution stride.
- LAT, 2, cycles from read issue to product valid at accumulator input (BRAM 1 + MAC 1).
- AW, 16, address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- start  in  1  begin layer; sampled only in IDLE.
- hold  in  1  suppresses new read issue while high.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at layer completion.
- mem_en  out  1  read enable, shared by ifm and weight buffers.
- ifm_addr  out  AW  ifm buffer word address.
- weight_addr  out  AW  weight buffer word address.
- acc_clear  out  1  accumulator load-not-add (first product of neuron).
- acc_enable  out  1  accumulator input valid.
- out_we  out  1  output buffer write strobe.
- out_addr  out  AW  output buffer address, valid with out_we.

Interface note (decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async, rst=1): state IDLE; all loop counters 0; all outputs 0; delay lines cleared. Reset mid-run aborts with no further writes and no done.
- States:
  - IDLE: start=1 → RUN.
  - RUN: issues reads; after the final issue → DRAIN.
  - DRAIN: waits until the final out_we has been emitted → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start is ignored outside IDLE. If start is held high, a new layer begins on the cycle after DONE.
- Issue rule (RUN, hold=0): mem_en=1 and counters advance by one step. With hold=1: mem_en=0 and counters freeze. Delay lines keep shifting (they shift in 0).
- Counter order, innermost first: n∈[0,NW), j∈[0,K), i∈[0,K), c∈[0,C), r∈[0,R), m∈[0,M). Each counter wraps to 0 and carries to the next.
- Addresses are combinational from the counters and valid with mem_en:
  - IW = (C−1)·S + K.
  - ifm_addr = ((r·S+i)·IW + (c·S+j))·NW + n.
  - weight_addr = ((m·K+i)·K + j)·NW + n.
  - Both truncated to AW; overflow is a configuration error and is not checked.
- Tags per issue:
  - first = (i=0, j=0, n=0).
  - last = (i=K−1, j=K−1, n=NW−1).
  - oaddr = (m·R + r)·C + c.
- Shift registers:
  - acc_enable(t) = issue(t−LAT).
  - acc_clear(t) = issue∧first(t−LAT).
  - out_we(t) = issue∧last(t−LAT−1); out_addr = oaddr of that same issue. The extra cycle covers the registered accumulator sum.
  - out_addr is held at its last value when out_we=0.
- Latency for a layer with T = M·R·C·K²·NW issues and no hold:
  - start sampled at edge t.
  - First mem_en at cycle t+1.
  - Final issue at cycle t+T.
  - Final out_we at cycle t+T+LAT+1.
  - done at cycle t+T+LAT+2.
  - busy high from t+1 through the done cycle inclusive.
- K=1, NW=1 case: first and last hold on the same issue, so acc_clear and out_we occur for every issue, and back-to-back neurons stream without bubbles.
- hold during DRAIN has no effect.

Test Plan:
- M=R=C=K=NW=1, LAT=2; start at t=0 → mem_en @1 with addrs 0/0; acc_clear+acc_enable @3; out_we @4 with out_addr 0; done @5; busy high cycles 1..5.
- K=3, NW=1, C=2, R=M=1 → 18 issues. Neuron c=1 ifm_addr sequence is 1,2,3,5,6,7,9,10,11. weight_addr is 0..8 for each neuron. out_we @ cycles 12 and 21 with addrs 0, 1. done @22.
- M=2, K=3, NW=2, R=C=1 → the first issue with m=1 has weight_addr=18, ifm_addr=0. out_addr is 0 then 1.
- Config of scenario 2 with hold=1 for 3 cycles during issue 5 → mem_en low for 3 cycles, address stream resumes unchanged, all out_we/done shifted by +3, no spurious acc_enable.
- Config of scenario 2 with start pulsed at cycle 6 (busy) → ignored, exactly 2 out_we. With start held high → second layer's first mem_en at cycle 23.
- Config of scenario 2 with rst asserted asynchronously mid-RUN at cycle 10 → all outputs 0 immediately, no out_we/done afterwards. A start after release runs a full clean layer.
